// File: rtl/mc_core_top.sv
`default_nettype none
// mc_core_top: multi-cycle 32-bit RISC core sequenced FETCH -> DECODE -> EXEC (-> MEM).
// Optional macro CORE_HALT_EN: opcode F halts until reset; otherwise opcode F is a NOP.
module mc_core_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_memory_addr,
  output logic        instr_memory_enable,
  input  logic [31:0] instr_memory_data,
  output logic [31:0] data_memory_addr,
  output logic [31:0] data_memory_wd,
  output logic        data_memory_we,
  input  logic [31:0] data_memory_data
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_xor  = 4'h5;
  localparam logic [3:0] c_op_sll  = 4'h6;
  localparam logic [3:0] c_op_srl  = 4'h7;
  localparam logic [3:0] c_op_addi = 4'h8;
  localparam logic [3:0] c_op_lui  = 4'h9;
  localparam logic [3:0] c_op_lw   = 4'hA;
  localparam logic [3:0] c_op_sw   = 4'hB;
  localparam logic [3:0] c_op_beq  = 4'hC;
  localparam logic [3:0] c_op_bne  = 4'hD;
  localparam logic [3:0] c_op_jal  = 4'hE;
  localparam logic [3:0] c_op_rsv  = 4'hF;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_regs [16];
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wd;
  logic        r_dm_we;

  // Load/store address is formed from the ROM word at DECODE so the bus is registered on entry to EXEC.
  logic [3:0]  w_d_op;
  logic [31:0] w_d_simm;
  logic [31:0] w_d_rs1;
  logic [31:0] w_d_rs2;
  logic [31:0] w_d_addr;

  assign w_d_op   = instr_memory_data[31:28];
  assign w_d_simm = {{16{instr_memory_data[15]}}, instr_memory_data[15:0]};
  assign w_d_rs1  = r_regs[instr_memory_data[23:20]];
  assign w_d_rs2  = r_regs[instr_memory_data[19:16]];
  assign w_d_addr = w_d_rs1 + w_d_simm;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [31:0] w_simm;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic [31:0] w_result;
  logic        w_wr;
  logic        w_jump;

  assign w_op     = r_ir[31:28];
  assign w_rd     = r_ir[27:24];
  assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_pc4    = r_pc + 32'd4;
  assign w_target = r_pc + {w_simm[29:0], 2'b00};

  always_comb begin
    w_result = '0;
    w_wr     = 1'b0;
    w_jump   = 1'b0;
    case (w_op)
      c_op_add:  begin w_result = r_a + r_b;             w_wr = 1'b1; end
      c_op_sub:  begin w_result = r_a - r_b;             w_wr = 1'b1; end
      c_op_and:  begin w_result = r_a & r_b;             w_wr = 1'b1; end
      c_op_or:   begin w_result = r_a | r_b;             w_wr = 1'b1; end
      c_op_xor:  begin w_result = r_a ^ r_b;             w_wr = 1'b1; end
      c_op_sll:  begin w_result = r_a << r_b[4:0];       w_wr = 1'b1; end
      c_op_srl:  begin w_result = r_a >> r_b[4:0];       w_wr = 1'b1; end
      c_op_addi: begin w_result = r_a + w_simm;          w_wr = 1'b1; end
      c_op_lui:  begin w_result = {r_ir[15:0], 16'h0};   w_wr = 1'b1; end
      c_op_beq:  w_jump = (r_a == r_b);
      c_op_bne:  w_jump = (r_a != r_b);
      c_op_jal:  begin w_result = w_pc4; w_wr = 1'b1; w_jump = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_dm_addr <= '0;
      r_dm_wd   <= '0;
      r_dm_we   <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= instr_memory_data;
          r_a  <= w_d_rs1;
          r_b  <= w_d_rs2;
          if (w_d_op == c_op_sw) begin
            r_dm_addr <= w_d_addr;
            r_dm_wd   <= w_d_rs2;
            r_dm_we   <= 1'b1;
          end else if (w_d_op == c_op_lw) begin
            r_dm_addr <= w_d_addr;
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_dm_we <= 1'b0;
          r_dm_wd <= '0;
          if (w_op == c_op_lw) begin
            r_state <= S_MEM;
          end
`ifdef CORE_HALT_EN
          else if (w_op == c_op_rsv) begin
            r_dm_addr <= '0;
            r_state   <= S_HALT;
          end
`endif
          else begin
            r_dm_addr <= '0;
            if (w_wr && (w_rd != 4'd0)) r_regs[w_rd] <= w_result;
            r_pc    <= w_jump ? w_target : w_pc4;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (w_rd != 4'd0) r_regs[w_rd] <= data_memory_data;
          r_dm_addr <= '0;
          r_pc      <= w_pc4;
          r_state   <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign instr_memory_addr   = r_pc;
  // Gated by reset so the strobe is low while held in reset yet high for the first edge after release.
  assign instr_memory_enable = (r_state == S_FETCH) && reset;
  assign data_memory_addr    = r_dm_addr;
  assign data_memory_wd      = r_dm_wd;
  assign data_memory_we      = r_dm_we;

  logic w_unused;
  assign w_unused = ^{c_op_rsv};

endmodule
`default_nettype wire

// File: tb/tb_mc_core_top.sv
`default_nettype none
// tb_mc_core_top: program-driven scoreboard bench for mc_core_top (fetches and stores checked in order).
module tb_mc_core_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_memory_addr;
  logic        instr_memory_enable;
  logic [31:0] instr_memory_data = '0;
  logic [31:0] data_memory_addr;
  logic [31:0] data_memory_wd;
  logic        data_memory_we;
  logic [31:0] data_memory_data = '0;

  mc_core_top #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_memory_addr   (instr_memory_addr),
    .instr_memory_enable (instr_memory_enable),
    .instr_memory_data   (instr_memory_data),
    .data_memory_addr    (data_memory_addr),
    .data_memory_wd      (data_memory_wd),
    .data_memory_we      (data_memory_we),
    .data_memory_data    (data_memory_data)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];

  always @(posedge clk) begin
    if (instr_memory_enable) instr_memory_data <= rom[instr_memory_addr[11:2]];
    data_memory_data <= data_memory_addr[12] ? ram[data_memory_addr[11:2]] : rom[data_memory_addr[11:2]];
    if (data_memory_we && data_memory_addr[12]) ram[data_memory_addr[11:2]] <= data_memory_wd;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fetch_q [$];
  logic [63:0] store_q [$];
  bit          mon_en = 1'b0;
  bit          prev_we = 1'b0;
  int          cyc, n_fetch, first_cyc, mark_cyc, n_watch;
  logic [31:0] mark_addr, watch_addr;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Scoreboard monitor: pops expected fetch addresses and stores as the core produces them.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      logic [31:0] ef;
      logic [63:0] es;
      cyc++;
      if (instr_memory_enable) begin
        if (n_fetch == 0) first_cyc = cyc;
        if (instr_memory_addr == mark_addr && mark_cyc < 0) mark_cyc = cyc;
        n_fetch++;
        if (fetch_q.size() > 0) begin
          ef = fetch_q.pop_front();
          n_checks++;
          if (instr_memory_addr !== ef) begin
            n_fail++;
            $display("FAIL fetch_addr: got %08h expected %08h", instr_memory_addr, ef);
          end
        end
      end
      if (watch_addr != 0 && data_memory_addr == watch_addr) n_watch++;
      if (data_memory_we) begin
        n_checks++;
        if (prev_we) begin
          n_fail++;
          $display("FAIL we_width: we high on consecutive cycles, addr %08h", data_memory_addr);
        end else if (store_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_store: got addr %08h wd %08h expected no store", data_memory_addr, data_memory_wd);
        end else begin
          es = store_q.pop_front();
          if ({data_memory_addr, data_memory_wd} !== es) begin
            n_fail++;
            $display("FAIL store: got %08h/%08h expected %08h/%08h", data_memory_addr, data_memory_wd, es[63:32], es[31:0]);
          end
        end
      end else if (data_memory_wd !== 32'h0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wd_idle: got %08h expected 00000000", data_memory_wd);
      end
      prev_we = data_memory_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic begin_test();
    mon_en = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
    fetch_q.delete();
    store_q.delete();
    cyc = 0; n_fetch = 0; first_cyc = -1; mark_cyc = -1; n_watch = 0;
    mark_addr = 32'hFFFF_FFFF;
    watch_addr = 32'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (fetch_q.size() != 0 || store_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: pending fetches %0d stores %0d expected 0 and 0", name, fetch_q.size(), store_q.size());
    end
  endtask

  task automatic test_reset();
    begin_test();
    n_checks++;
    if ({instr_memory_addr, instr_memory_enable, data_memory_addr, data_memory_wd, data_memory_we} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ia=%08h en=%b da=%08h wd=%08h we=%b expected all 0",
               instr_memory_addr, instr_memory_enable, data_memory_addr, data_memory_wd, data_memory_we);
    end
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4); fetch_q.push_back(32'h8);
    mark_addr = 32'h8;
    release_reset();
    repeat (9) @(negedge clk);
    n_checks++;
    if (mark_cyc - first_cyc !== 6) begin
      n_fail++;
      $display("FAIL nop_cpi: third fetch %0d cycles after first, expected 6", mark_cyc - first_cyc);
    end
    check_drained("reset");
  endtask

  task automatic test_alu_mem();
    begin_test();
    rom[0]  = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h1000);
    rom[1]  = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'h0005);
    rom[2]  = enc(4'hB, 4'd0, 4'd1, 4'd2, 16'h0010);
    rom[3]  = enc(4'hA, 4'd3, 4'd1, 4'd0, 16'h0010);
    rom[4]  = enc(4'h1, 4'd4, 4'd3, 4'd3, 16'h0000);
    rom[5]  = enc(4'hB, 4'd0, 4'd1, 4'd4, 16'h0014);
    rom[6]  = enc(4'h9, 4'd6, 4'd0, 4'd0, 16'hDEAD);
    rom[7]  = enc(4'h8, 4'd7, 4'd0, 4'd0, 16'd31);
    rom[8]  = enc(4'h7, 4'd8, 4'd6, 4'd7, 16'h0);
    rom[9]  = enc(4'h6, 4'd9, 4'd2, 4'd7, 16'h0);
    rom[10] = enc(4'h2, 4'd10, 4'd0, 4'd2, 16'h0);
    rom[11] = enc(4'hB, 4'd0, 4'd1, 4'd6, 16'h0020);
    rom[12] = enc(4'hB, 4'd0, 4'd1, 4'd8, 16'h0024);
    rom[13] = enc(4'hB, 4'd0, 4'd1, 4'd9, 16'h0028);
    rom[14] = enc(4'hB, 4'd0, 4'd1, 4'd10, 16'h002C);
    rom[15] = enc(4'h8, 4'd0, 4'd0, 4'd0, 16'h0007);
    rom[16] = enc(4'hB, 4'd0, 4'd1, 4'd0, 16'h0030);
    rom[17] = enc(4'h3, 4'd11, 4'd10, 4'd4, 16'h0);
    rom[18] = enc(4'h4, 4'd12, 4'd6, 4'd2, 16'h0);
    rom[19] = enc(4'h5, 4'd13, 4'd10, 4'd2, 16'h0);
    rom[20] = enc(4'hB, 4'd0, 4'd1, 4'd11, 16'h0034);
    rom[21] = enc(4'hB, 4'd0, 4'd1, 4'd12, 16'h0038);
    rom[22] = enc(4'hB, 4'd0, 4'd1, 4'd13, 16'h003C);
    rom[23] = enc(4'h1, 4'd14, 4'd10, 4'd9, 16'h0);
    rom[24] = enc(4'hB, 4'd0, 4'd1, 4'd14, 16'h0040);
    rom[25] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000);
    store_q.push_back({32'h1010, 32'h5});
    store_q.push_back({32'h1014, 32'hA});
    store_q.push_back({32'h1020, 32'hDEAD_0000});
    store_q.push_back({32'h1024, 32'h1});
    store_q.push_back({32'h1028, 32'h8000_0000});
    store_q.push_back({32'h102C, 32'hFFFF_FFFB});
    store_q.push_back({32'h1030, 32'h0});
    store_q.push_back({32'h1034, 32'hA});
    store_q.push_back({32'h1038, 32'hDEAD_0005});
    store_q.push_back({32'h103C, 32'hFFFF_FFFE});
    store_q.push_back({32'h1040, 32'h7FFF_FFFB});
    mark_addr  = 32'h64;
    watch_addr = 32'h1010;
    release_reset();
    repeat (100) @(negedge clk);
    n_checks++;
    if (n_watch !== 3) begin
      n_fail++;
      $display("FAIL addr_1010_cycles: got %0d expected 3", n_watch);
    end
    n_checks++;
    if (mark_cyc - first_cyc !== 76) begin
      n_fail++;
      $display("FAIL cpi_total: fetch of 0x64 at +%0d cycles expected +76", mark_cyc - first_cyc);
    end
    check_drained("alu_mem");
  endtask

  task automatic test_branches();
    logic [31:0] seq [13];
    seq = '{32'h00, 32'h04, 32'h20, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h34, 32'h40, 32'h50, 32'h54, 32'h58};
    begin_test();
    rom[0]  = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h1000);
    rom[1]  = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0007);
    rom[6]  = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'h0001);
    rom[8]  = enc(4'hC, 4'd0, 4'd2, 4'd0, 16'hFFFE);
    rom[9]  = enc(4'hE, 4'd0, 4'd0, 4'd0, 16'h0003);
    rom[12] = enc(4'hD, 4'd0, 4'd0, 4'd0, 16'h0008);
    rom[13] = enc(4'hD, 4'd0, 4'd1, 4'd0, 16'h0003);
    rom[16] = enc(4'hE, 4'd5, 4'd0, 4'd0, 16'h0004);
    rom[20] = enc(4'hB, 4'd0, 4'd1, 4'd5, 16'h0000);
    rom[21] = enc(4'hB, 4'd0, 4'd1, 4'd2, 16'h0004);
    rom[22] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000);
    foreach (seq[i]) fetch_q.push_back(seq[i]);
    store_q.push_back({32'h1000, 32'h44});
    store_q.push_back({32'h1004, 32'h1});
    release_reset();
    repeat (60) @(negedge clk);
    check_drained("branches");
  endtask

  task automatic test_loop();
    begin_test();
    rom[0] = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h1190);
    rom[1] = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'h0003);
    rom[2] = enc(4'hB, 4'd0, 4'd1, 4'd2, 16'h0000);
    rom[3] = enc(4'hA, 4'd3, 4'd1, 4'd0, 16'h0000);
    rom[4] = enc(4'h8, 4'd2, 4'd2, 4'd0, 16'hFFFF);
    rom[5] = enc(4'hD, 4'd0, 4'd2, 4'd0, 16'hFFFD);
    rom[6] = enc(4'hB, 4'd0, 4'd1, 4'd3, 16'h0004);
    rom[7] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000);
    store_q.push_back({32'h1190, 32'h3});
    store_q.push_back({32'h1190, 32'h2});
    store_q.push_back({32'h1190, 32'h1});
    store_q.push_back({32'h1194, 32'h1});
    watch_addr = 32'h1190;
    release_reset();
    repeat (120) @(negedge clk);
    n_checks++;
    if (n_watch !== 9) begin
      n_fail++;
      $display("FAIL addr_1190_cycles: got %0d expected 9", n_watch);
    end
    check_drained("loop");
  endtask

  task automatic test_reset_mid_sw();
    begin_test();
    rom[0] = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h1000);
    rom[1] = enc(4'hB, 4'd0, 4'd1, 4'd1, 16'h0000);
    ram[0] = 32'hA5A5_A5A5;
    store_q.push_back({32'h1000, 32'h1000});
    release_reset();
    for (int i = 0; i < 20 && !data_memory_we; i++) @(negedge clk);
    n_checks++;
    if (!data_memory_we) begin
      n_fail++;
      $display("FAIL sw_timeout: we=%b expected 1 within 20 cycles", data_memory_we);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({instr_memory_addr, instr_memory_enable, data_memory_addr, data_memory_wd, data_memory_we} !== '0) begin
      n_fail++;
      $display("FAIL abort_sw: got ia=%08h en=%b da=%08h wd=%08h we=%b expected all 0",
               instr_memory_addr, instr_memory_enable, data_memory_addr, data_memory_wd, data_memory_we);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ram[0] !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL abort_sw_ram: got %08h expected a5a5a5a5", ram[0]);
    end
    check_drained("abort_sw");
    // r1 was written before the abort; after reset it must read zero again.
    begin_test();
    rom[0] = enc(4'hB, 4'd0, 4'd0, 4'd1, 16'h1008);
    rom[1] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000);
    store_q.push_back({32'h1008, 32'h0});
    release_reset();
    repeat (12) @(negedge clk);
    check_drained("regs_cleared");
  endtask

  task automatic test_opcode_f();
    begin_test();
    rom[0] = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h1000);
    rom[1] = 32'hF000_0000;
    rom[2] = enc(4'hB, 4'd0, 4'd1, 4'd1, 16'h0000);
    rom[3] = enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000);
    fetch_q.push_back(32'h0);
    fetch_q.push_back(32'h4);
`ifndef CORE_HALT_EN
    fetch_q.push_back(32'h8);
    fetch_q.push_back(32'hC);
    store_q.push_back({32'h1000, 32'h1000});
`endif
    release_reset();
    repeat (40) @(negedge clk);
`ifdef CORE_HALT_EN
    n_checks++;
    if (n_fetch !== 2 || instr_memory_enable !== 1'b0 || data_memory_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL halt: fetches %0d en=%b da=%08h expected 2, 0, 00000000", n_fetch, instr_memory_enable, data_memory_addr);
    end
`else
    n_checks++;
    if (!(n_fetch >= 5)) begin
      n_fail++;
      $display("FAIL opf_nop: fetches %0d expected at least 5", n_fetch);
    end
`endif
    check_drained("opcode_f");
  endtask

  initial begin
    test_reset();
    test_alu_mem();
    test_branches();
    test_loop();
    test_reset_mid_sw();
    test_opcode_f();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
